// File: rtl/ms_jk_bank_pkg.sv
// Shared types for the master-slave flip-flop bank.
// Mode encodings and the common reset value.
package ms_jk_pkg;

    typedef enum logic [1:0] {
        MODE_JK = 2'b00,
        MODE_SR = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_e;

    localparam logic RST_VAL = 1'b0;

endpackage

// File: rtl/ms_jk_bank_if.sv
// Control/data bundle of the master-slave bank.
// master drives the controls, slave is the bank.
interface ms_jk_bank_if #(
    parameter int WIDTH = 4
);
    logic [1:0]       mode;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] qm;
    logic [WIDTH-1:0] qs;
    logic             chg;
    logic             err;

    modport master (
        output mode, en, load, din, j, k,
        input  qm, qs, chg, err
    );

    modport slave (
        input  mode, en, load, din, j, k,
        output qm, qs, chg, err
    );
endinterface

// File: rtl/ms_jk_bank_cell.sv
// Per-bit next-state function of one master-slave cell.
// SR with j=k=1 holds and flags illegal.
module ms_jk_cell
    import ms_jk_pkg::*;
(
    input  mode_e mode,
    input  logic  j,
    input  logic  k,
    input  logic  q,
    output logic  nq,
    output logic  illegal
);
    always_comb begin
        nq      = q;
        illegal = 1'b0;
        unique case (mode)
            MODE_JK: nq = (j & ~q) | (~k & q);
            MODE_SR: begin
                illegal = j & k;
                nq      = (j & ~k) | (~(j ^ k) & q);
            end
            MODE_D:  nq = j;
            MODE_T:  nq = j ^ q;
        endcase
    end
endmodule

// File: rtl/ms_jk_bank.sv
// Bank of WIDTH master-slave cells: master on rising, slave on falling edge.
// Define MS_JK_SR_ERR_EN to build the sticky SR-illegal detector.
module ms_jk_bank
    import ms_jk_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input logic         clk,
    input logic         res,
    ms_jk_bank_if.slave bus
);
    mode_e            mode;
    logic [WIDTH-1:0] nq;
    logic [WIDTH-1:0] ill;
    logic [WIDTH-1:0] qm;
    logic [WIDTH-1:0] qs;
    logic             chg;

    assign mode = mode_e'(bus.mode);

    // Feedback from the slave keeps the master free of races while clk is high.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ms_jk_cell u_cell (
            .mode    (mode),
            .j       (bus.j[i]),
            .k       (bus.k[i]),
            .q       (qs[i]),
            .nq      (nq[i]),
            .illegal (ill[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            qm  <= {WIDTH{RST_VAL}};
            chg <= 1'b0;
        end else if (bus.load) begin
            qm  <= bus.din;
            chg <= bus.din != qm;
        end else if (bus.en) begin
            qm  <= nq;
            chg <= nq != qm;
        end else begin
            chg <= 1'b0;
        end
    end

    always_ff @(negedge clk) begin
        if (!res) begin
            qs <= {WIDTH{RST_VAL}};
        end else begin
            qs <= qm;
        end
    end

`ifdef MS_JK_SR_ERR_EN
    logic err;

    always_ff @(posedge clk) begin
        if (!res) begin
            err <= 1'b0;
        end else if (mode == MODE_SR && bus.en && !bus.load && |ill) begin
            err <= 1'b1;
        end
    end
`else
    logic err;
    logic unused_ill;

    assign err        = 1'b0;
    assign unused_ill = |ill;
`endif

    assign bus.qm  = qm;
    assign bus.qs  = qs;
    assign bus.chg = chg;
    assign bus.err = err;
endmodule

// File: tb/tb_ms_jk_bank.sv
// Self-checking bench for ms_jk_bank: directed plan plus random traffic
// against a per-bit truth-table reference model.
module tb_ms_jk_bank;
    import ms_jk_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic res = 1'b0;

    ms_jk_bank_if #(.WIDTH(W)) bus ();

    ms_jk_bank #(.WIDTH(W)) dut (
        .clk (clk),
        .res (res),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int m_qm  = 0;
    int m_qs  = 0;
    int m_chg = 0;
    int m_err = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int next_bit(int md, int jb, int kb, int q);
        case (md)
            0: begin
                if (jb && kb) return 1 - q;
                if (jb) return 1;
                if (kb) return 0;
                return q;
            end
            1: begin
                if (jb && !kb) return 1;
                if (kb && !jb) return 0;
                return q;
            end
            2: return jb;
            default: return jb ? 1 - q : q;
        endcase
    endfunction

    task automatic model_rise();
        int nq;
        int bad;
        if (!res) begin
            m_qm  = 0;
            m_chg = 0;
            m_err = 0;
        end else if (bus.load) begin
            m_chg = (int'(bus.din) != m_qm);
            m_qm  = int'(bus.din);
        end else if (bus.en) begin
            nq  = 0;
            bad = 0;
            for (int b = 0; b < W; b++) begin
                nq += next_bit(int'(bus.mode), int'(bus.j[b]), int'(bus.k[b]),
                               (m_qs >> b) & 1) << b;
                if (bus.mode == 2'b01 && bus.j[b] && bus.k[b]) bad = 1;
            end
`ifdef MS_JK_SR_ERR_EN
            if (bad) m_err = 1;
`endif
            m_chg = (nq != m_qm);
            m_qm  = nq;
        end else begin
            m_chg = 0;
        end
    endtask

    task automatic step(bit res_pulse = 1'b0);
        @(posedge clk);
        model_rise();
        #1;
        if (res_pulse) res = 1'b1;
        check("qm", {28'd0, bus.qm}, m_qm);
        check("chg", {31'd0, bus.chg}, m_chg);
        check("err", {31'd0, bus.err}, m_err);
        @(negedge clk);
        m_qs = res ? m_qm : 0;
        #1;
        check("qs", {28'd0, bus.qs}, m_qs);
        #1;
    endtask

    task automatic drive(logic [1:0] md, logic l, logic e,
                         logic [W-1:0] d, logic [W-1:0] jj, logic [W-1:0] kk);
        bus.mode = md;
        bus.load = l;
        bus.en   = e;
        bus.din  = d;
        bus.j    = jj;
        bus.k    = kk;
    endtask

    initial begin
        logic sr_err;
`ifdef MS_JK_SR_ERR_EN
        sr_err = 1'b1;
`else
        sr_err = 1'b0;
`endif
        drive(2'b00, 1'b0, 1'b1, 4'h0, 4'hF, 4'hF);
        res = 1'b0;
        step();
        step();
        check("rst_qs", {28'd0, bus.qs}, 0);
        res = 1'b1;
        step();
        check("rel_qm", {28'd0, bus.qm}, 32'hF);
        check("rel_chg", {31'd0, bus.chg}, 1);

        drive(2'b00, 1'b1, 1'b1, 4'b0101, 4'h0, 4'h0);
        step();
        drive(2'b00, 1'b0, 1'b1, 4'h0, 4'b0011, 4'b0101);
        step();
        check("jk_sweep", {28'd0, bus.qs}, 32'b0010);

        drive(2'b11, 1'b1, 1'b1, 4'b1001, 4'hF, 4'h0);
        step();
        check("load_prio", {28'd0, bus.qm}, 32'b1001);
        step();
        check("load_same", {31'd0, bus.chg}, 0);

        drive(2'b10, 1'b0, 1'b1, 4'h0, 4'b1100, 4'h0);
        step();
        check("d_mode", {28'd0, bus.qs}, 32'b1100);
        drive(2'b11, 1'b0, 1'b1, 4'h0, 4'b0110, 4'h0);
        step();
        check("t_mode", {28'd0, bus.qs}, 32'b1010);
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("hold", {28'd0, bus.qs}, 32'b1010);

        drive(2'b00, 1'b1, 1'b1, 4'b0011, 4'h0, 4'h0);
        step();
        drive(2'b01, 1'b0, 1'b1, 4'h0, 4'b0001, 4'b0001);
        step();
        check("sr_hold", {28'd0, bus.qm}, 32'b0011);
        check("sr_err", {31'd0, bus.err}, {31'd0, sr_err});
        bus.en = 1'b0;
        step();
        check("sr_sticky", {31'd0, bus.err}, {31'd0, sr_err});
        res = 1'b0;
        step();
        res = 1'b1;
        check("err_clr", {31'd0, bus.err}, 0);

        for (int i = 0; i < 300; i++) begin
            drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 3) != 0), 4'($urandom),
                  4'($urandom), 4'($urandom));
            res = ($urandom_range(0, 24) != 0);
            step();
        end

        res = 1'b1;
        drive(2'b00, 1'b1, 1'b1, 4'hF, 4'h0, 4'h0);
        step();
        res = 1'b0;
        step(1'b1);
        check("mid_rst_qm", {28'd0, bus.qm}, 0);
        check("mid_rst_qs", {28'd0, bus.qs}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
